switch_mcu_alu_imm_seq: RTL
===========================

// Module: switch_mcu_alu_imm_seq
// PURPOSE
//  Parametrised successor to the per-op immediate ALU units: one sequenced unit executing all
//  RV32I/RV64I OP-IMM ops (ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI) against the reg file.
//  Own FSM with start/done handshake, configurable read latency, iterative shifter.
//  Sits between the decoder (start, fields) and the reg-file read port 1 / write port.
// PARAMETERS
//  XLEN        32  datapath width; 32 or 64
//  REG_AW      5   register address width
//  RD_LAT      1   cycles from out_ren_1 high to in_rdata_1 valid; 1..4
//  SHIFT_STEP  1   max bits shifted per EXEC cycle; power of 2, 1..XLEN
// PORTS
//  in_clk          in   1        clock, all state on rising edge
//  in_rst          in   1        synchronous, active-high reset
//  in_start        in   1        start pulse; sampled only in IDLE
//  in_funct3       in   3        OP-IMM funct3
//  in_imm_type_i   in   12       I-type immediate (incl. funct7/shamt bits)
//  in_rs1          in   REG_AW   source register
//  in_rd           in   REG_AW   destination register
//  in_rdata_1      in   XLEN     read port 1 data
//  out_raddr_1     out  REG_AW   read port 1 address
//  out_ren_1       out  1        read port 1 enable
//  out_waddr       out  REG_AW   write address
//  out_wen         out  1        write enable
//  out_wdata       out  XLEN     write data
//  out_busy        out  1        high in every state except IDLE
//  out_done        out  1        one-cycle completion pulse
//  out_illegal     out  1        one-cycle pulse with out_done on illegal encoding
// BEHAVIOUR
//  - All outputs registered; reset value 0 for every output; FSM -> IDLE.
//  - FSM: IDLE -> READ (1 cyc) -> WAIT (RD_LAT cyc) -> EXEC (N cyc) -> WB (1 cyc) -> IDLE.
//  - IDLE & in_start: latch funct3, imm, rs1, rd; later input changes ignored. in_start outside
//    IDLE is ignored (no queueing). Back-to-back: start accepted the cycle after WB.
//  - READ: out_ren_1=1, out_raddr_1=rs1; otherwise both 0. Operand captured at last WAIT cycle.
//  - imm sign-extended to XLEN. SLTI signed, SLTIU unsigned compare vs sign-extended imm; result
//    0/1 zero-extended. ADDI wraps modulo 2^XLEN, no overflow flag.
//  - Shifts: shamt = imm[log2(XLEN)-1:0]. N = max(1, ceil(shamt/SHIFT_STEP)); each EXEC cycle
//    shifts by min(SHIFT_STEP, remaining). shamt=0 -> result = rs1. Non-shift ops: N=1.
//  - Illegal: SLLI with imm[11:log2 XLEN] != 0; SRLI/SRAI with those bits != 0 other than imm[10]
//    (imm[10]=1 selects SRAI). Illegal skips EXEC; WB gives out_done=1, out_illegal=1, out_wen=0.
//  - WB: out_done=1; if rd!=0 and legal: out_wen=1, out_waddr=rd, out_wdata=result; rd==0: no write.
//    out_waddr/out_wdata are 0 whenever out_wen=0.
//  - Latency (RD_LAT=1, non-shift): start at edge 0 -> ren cycle 1, write/done cycle 4.
//    General: done at cycle 2 + RD_LAT + N (illegal: 2 + RD_LAT).
//  - in_rst asserted in any state: next edge -> IDLE, all outputs 0, no write, no done pulse.
// STRUCTURE
//  - Shared defs (switch_mcu_alu_defs): funct3 codes, FSM state encodings, SHAMT_W = $clog2(XLEN).
//  - One sub-module: switch_mcu_alu_shift_iter (load, step, remaining shamt, dir, arith; done flag).
//  - Top holds FSM, operand/field registers, op mux, illegal check, port drivers.
// TESTING
//  - XORI rs1=x5=0x0000_00FF, imm=0x801, rd=x6 -> cycle 4: wen=1, waddr=6, wdata=0xFFFF_F8FE.
//  - SLTIU x1=1, imm=0xFFF -> wdata=1; SLTI same operands -> wdata=0.
//  - SRAI x2=0x8000_0000, imm=0x41F, SHIFT_STEP=1 -> 31 EXEC cycles, done cycle 34, wdata=0xFFFF_FFFF.
//  - SLLI imm=0x020 (XLEN=32) -> done=1, illegal=1, wen=0; ADDI rd=x0 -> done=1, wen=0.
//  - RD_LAT=3, ADDI x3=0x7FFF_FFFF, imm=1 -> done cycle 6, wdata=0x8000_0000; in_start mid-op ignored.
//  - in_rst pulsed in EXEC of a shift -> no wen/done; busy=0 next cycle; fresh start completes.

Source files
------------

// File: rtl/switch_mcu_alu_imm_seq_pkg.sv
// Shared definitions for the sequenced OP-IMM ALU: funct3 codes, FSM states and
// small helpers used by the top and the iterative shifter.
package switch_mcu_alu_imm_seq_pkg;

    typedef enum logic [2:0] {
        F3_ADDI  = 3'b000,
        F3_SLLI  = 3'b001,
        F3_SLTI  = 3'b010,
        F3_SLTIU = 3'b011,
        F3_XORI  = 3'b100,
        F3_SRXI  = 3'b101,
        F3_ORI   = 3'b110,
        F3_ANDI  = 3'b111
    } funct3_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_WAIT = 3'd2,
        ST_EXEC = 3'd3,
        ST_WB   = 3'd4
    } state_e;

    localparam int IMM_W     = 12;
    localparam int LAT_CNT_W = 3;
    // imm[10] distinguishes SRAI from SRLI and is not part of the shamt field
    localparam logic [IMM_W-1:0] SRA_BIT = 12'h400;

    function automatic int shamt_w(input int xlen);
        return $clog2(xlen);
    endfunction

    function automatic logic is_shift(input funct3_e f3);
        return (f3 == F3_SLLI) || (f3 == F3_SRXI);
    endfunction

endpackage

// File: rtl/switch_mcu_alu_imm_seq_if.sv
// Decoder / register-file facing bundle of the sequenced OP-IMM ALU.
// slave is the ALU side; master is the decoder + register-file side.
interface switch_mcu_alu_imm_seq_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    import switch_mcu_alu_imm_seq_pkg::*;

    logic                in_start;
    logic [2:0]          in_funct3;
    logic [IMM_W-1:0]    in_imm_type_i;
    logic [REG_AW-1:0]   in_rs1;
    logic [REG_AW-1:0]   in_rd;
    logic [XLEN-1:0]     in_rdata_1;
    logic [REG_AW-1:0]   out_raddr_1;
    logic                out_ren_1;
    logic [REG_AW-1:0]   out_waddr;
    logic                out_wen;
    logic [XLEN-1:0]     out_wdata;
    logic                out_busy;
    logic                out_done;
    logic                out_illegal;

    modport slave (
        input  in_start, in_funct3, in_imm_type_i, in_rs1, in_rd, in_rdata_1,
        output out_raddr_1, out_ren_1, out_waddr, out_wen, out_wdata,
        output out_busy, out_done, out_illegal
    );

    modport master (
        output in_start, in_funct3, in_imm_type_i, in_rs1, in_rd, in_rdata_1,
        input  out_raddr_1, out_ren_1, out_waddr, out_wen, out_wdata,
        input  out_busy, out_done, out_illegal
    );

endinterface

// File: rtl/switch_mcu_alu_imm_seq_shift_iter.sv
// Iterative shifter: loaded with operand and shift amount, then moves at most
// SHIFT_STEP bits per step until the remaining amount is exhausted.
module switch_mcu_alu_imm_seq_shift_iter
    import switch_mcu_alu_imm_seq_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic                        i_load,
    input  logic [XLEN-1:0]             i_value,
    input  logic [shamt_w(XLEN)-1:0]    i_shamt,
    input  logic                        i_left,
    input  logic                        i_arith,
    input  logic                        i_step,
    output logic [XLEN-1:0]             o_next_value,
    output logic                        o_last
);
    localparam int SHAMT_W = shamt_w(XLEN);
    localparam int AMT_W   = SHAMT_W + 1;
    localparam logic [AMT_W-1:0] STEP_AMT = AMT_W'(SHIFT_STEP);

    logic [XLEN-1:0]    r_value;
    logic [SHAMT_W-1:0] r_remaining;
    logic               r_left;
    logic               r_arith;

    logic [AMT_W-1:0]   w_rem_ext;
    logic [AMT_W-1:0]   w_amt;

    assign w_rem_ext = {1'b0, r_remaining};
    assign w_amt     = (w_rem_ext > STEP_AMT) ? STEP_AMT : w_rem_ext;
    // the step in progress is the last one once it consumes everything left
    assign o_last    = (w_rem_ext <= STEP_AMT);

    always_comb begin
        o_next_value = r_value;
        if (r_left) begin
            o_next_value = r_value << w_amt;
        end else if (r_arith) begin
            o_next_value = $unsigned($signed(r_value) >>> w_amt);
        end else begin
            o_next_value = r_value >> w_amt;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_value     <= '0;
            r_remaining <= '0;
            r_left      <= 1'b0;
            r_arith     <= 1'b0;
        end else if (i_load) begin
            r_value     <= i_value;
            r_remaining <= i_shamt;
            r_left      <= i_left;
            r_arith     <= i_arith;
        end else if (i_step) begin
            r_value     <= o_next_value;
            r_remaining <= r_remaining - w_amt[SHAMT_W-1:0];
        end
    end

endmodule

// File: rtl/switch_mcu_alu_imm_seq.sv
// Sequenced OP-IMM ALU: reads rs1 through a latency-configurable port, executes
// one I-type op (shifts iteratively) and writes the result back to rd.
module switch_mcu_alu_imm_seq
    import switch_mcu_alu_imm_seq_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_AW     = 5,
    parameter int RD_LAT     = 1,
    parameter int SHIFT_STEP = 1
) (
    input  logic                     in_clk,
    input  logic                     in_rst,
    switch_mcu_alu_imm_seq_if.slave  bus
);
    localparam int SHAMT_W = shamt_w(XLEN);
    localparam logic [IMM_W-1:0] HI_MASK = IMM_W'(12'hFFF << SHAMT_W);

    state_e              r_state;
    state_e              w_state_next;

    funct3_e             r_funct3;
    logic [IMM_W-1:0]    r_imm;
    logic [REG_AW-1:0]   r_rs1;
    logic [REG_AW-1:0]   r_rd;
    logic [XLEN-1:0]     r_operand;
    logic [LAT_CNT_W-1:0] r_lat_cnt;

    logic                r_ren;
    logic [REG_AW-1:0]   r_raddr;
    logic                r_wen;
    logic [REG_AW-1:0]   r_waddr;
    logic [XLEN-1:0]     r_wdata;
    logic                r_busy;
    logic                r_done;
    logic                r_illegal;

    logic                w_ren_next;
    logic [REG_AW-1:0]   w_raddr_next;
    logic                w_wen_next;
    logic [REG_AW-1:0]   w_waddr_next;
    logic [XLEN-1:0]     w_wdata_next;
    logic                w_busy_next;
    logic                w_done_next;
    logic                w_illegal_next;

    logic [XLEN-1:0]     w_imm_sext;
    logic [IMM_W-1:0]    w_imm_hi;
    logic                w_shift_op;
    logic                w_illegal;
    logic                w_lat_last;
    logic                w_shift_load;
    logic                w_shift_step;
    logic                w_shift_last;
    logic [XLEN-1:0]     w_shift_value;
    logic [XLEN-1:0]     w_result;

    assign w_imm_sext = {{(XLEN-IMM_W){r_imm[IMM_W-1]}}, r_imm};
    assign w_imm_hi   = r_imm & HI_MASK;
    assign w_shift_op = is_shift(r_funct3);
    assign w_illegal  = ((r_funct3 == F3_SLLI) && (w_imm_hi != '0)) ||
                        ((r_funct3 == F3_SRXI) && ((w_imm_hi & ~SRA_BIT) != '0));
    assign w_lat_last = (r_lat_cnt == LAT_CNT_W'(RD_LAT - 1));

    // shifter is loaded straight from the read port on the operand-capture edge
    assign w_shift_load = (r_state == ST_WAIT) && w_lat_last;
    assign w_shift_step = (r_state == ST_EXEC) && w_shift_op;

    switch_mcu_alu_imm_seq_shift_iter #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shift (
        .clk          (in_clk),
        .srst         (in_rst),
        .i_load       (w_shift_load),
        .i_value      (bus.in_rdata_1),
        .i_shamt      (r_imm[SHAMT_W-1:0]),
        .i_left       (r_funct3 == F3_SLLI),
        .i_arith      (r_imm[10]),
        .i_step       (w_shift_step),
        .o_next_value (w_shift_value),
        .o_last       (w_shift_last)
    );

    always_comb begin
        w_result = '0;
        case (r_funct3)
            F3_ADDI:  w_result = r_operand + w_imm_sext;
            F3_SLTI:  w_result = {{(XLEN-1){1'b0}}, ($signed(r_operand) < $signed(w_imm_sext))};
            F3_SLTIU: w_result = {{(XLEN-1){1'b0}}, (r_operand < w_imm_sext)};
            F3_XORI:  w_result = r_operand ^ w_imm_sext;
            F3_ORI:   w_result = r_operand | w_imm_sext;
            F3_ANDI:  w_result = r_operand & w_imm_sext;
            F3_SLLI,
            F3_SRXI:  w_result = w_shift_value;
            default:  w_result = '0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_start) w_state_next = ST_READ;
            ST_READ: w_state_next = ST_WAIT;
            ST_WAIT: if (w_lat_last) w_state_next = w_illegal ? ST_WB : ST_EXEC;
            ST_EXEC: if (!w_shift_op || w_shift_last) w_state_next = ST_WB;
            ST_WB:   w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase

        // outputs are registered, so they are derived from the state being entered
        w_busy_next    = (w_state_next != ST_IDLE);
        w_ren_next     = (w_state_next == ST_READ);
        w_raddr_next   = w_ren_next ? bus.in_rs1 : '0;
        w_done_next    = (w_state_next == ST_WB);
        w_illegal_next = w_done_next && w_illegal;
        w_wen_next     = w_done_next && !w_illegal && (r_rd != '0);
        w_waddr_next   = w_wen_next ? r_rd : '0;
        w_wdata_next   = w_wen_next ? w_result : '0;
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_funct3  <= F3_ADDI;
            r_imm     <= '0;
            r_rs1     <= '0;
            r_rd      <= '0;
            r_operand <= '0;
            r_lat_cnt <= '0;
        end else begin
            if ((r_state == ST_IDLE) && bus.in_start) begin
                r_funct3 <= funct3_e'(bus.in_funct3);
                r_imm    <= bus.in_imm_type_i;
                r_rs1    <= bus.in_rs1;
                r_rd     <= bus.in_rd;
            end
            if (r_state == ST_READ) begin
                r_lat_cnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_lat_cnt <= r_lat_cnt + 1'b1;
            end
            if (w_shift_load) begin
                r_operand <= bus.in_rdata_1;
            end
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_ren     <= 1'b0;
            r_raddr   <= '0;
            r_wen     <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_ren     <= w_ren_next;
            r_raddr   <= w_raddr_next;
            r_wen     <= w_wen_next;
            r_waddr   <= w_waddr_next;
            r_wdata   <= w_wdata_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
            r_illegal <= w_illegal_next;
        end
    end

    assign bus.out_ren_1   = r_ren;
    assign bus.out_raddr_1 = r_raddr;
    assign bus.out_wen     = r_wen;
    assign bus.out_waddr   = r_waddr;
    assign bus.out_wdata   = r_wdata;
    assign bus.out_busy    = r_busy;
    assign bus.out_done    = r_done;
    assign bus.out_illegal = r_illegal;

endmodule
